reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single synchronous write port of the 32x64 register file among NUM_REQ writeback sources, for example ALU writeback, load writeback and debug/init.
- Grants one source per cycle using round-robin arbitration with a valid/ready handshake.
- Drives the register file's write-enable, write-address and write-data inputs from registered outputs.
- Sits between the writeback stage sources and the register file.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 64, register data width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- HOLD  in  1  stall; while 1, no grant is issued.
- REQ_VALID  in  NUM_REQ  per-requester write request.
- REQ_ADDR  in  NUM_REQ*ADDR_W  packed destination registers; requester i occupies bits [i*ADDR_W +: ADDR_W].
- REQ_DATA  in  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- REQ_READY  out  NUM_REQ  one-hot grant, combinational.
- REG_WRITE_ENABLE  out  1  registered write strobe to the register file.
- WRITE_REG  out  ADDR_W  registered write address.
- WRITE_DATA  out  DATA_W  registered write data.
- GRANT_ID  out  3  index of the requester that produced the current write.
- PENDING  out  NUM_REQ  registered; bit i=1 when requester i has waited at least 1 cycle.

Behaviour:
- Reset (RST_N=0, asynchronous) sets:
  - REG_WRITE_ENABLE=0, WRITE_REG=0, WRITE_DATA=0, GRANT_ID=0, PENDING=0.
  - Round-robin pointer LAST=NUM_REQ-1, so requester 0 has top priority on the first arbitration.
- REQ_READY is combinational from REQ_VALID, LAST and HOLD. No combinational path exists from REQ_ADDR or REQ_DATA to REQ_READY.
- Arbitration:
  - Scan indices starting at LAST+1 (mod NUM_REQ) and wrapping.
  - The first index with REQ_VALID=1 receives READY=1; all others receive 0.
  - If HOLD=1 or no requester is valid, REQ_READY is all zeros.
- Handshake occurs on requester i when REQ_VALID[i] & REQ_READY[i] at a rising edge. On that edge:
  - WRITE_REG<=REQ_ADDR[i], WRITE_DATA<=REQ_DATA[i], GRANT_ID<=i, REG_WRITE_ENABLE<=1, LAST<=i.
  - The register file captures the write on the following edge. Total latency from handshake to register update is 2 edges.
- No handshake in a cycle: REG_WRITE_ENABLE<=0 on that edge. WRITE_REG, WRITE_DATA and GRANT_ID hold their previous values.
- Throughput is 1 write per cycle. Back-to-back grants to the same requester happen only when no other requester is valid.
- Requester obligation (the block does not check it): once VALID is asserted, ADDR and DATA stay stable and VALID stays high until READY.
- PENDING[i]<=REQ_VALID[i] & ~(REQ_VALID[i] & REQ_READY[i]), updated every edge.
- Fairness: with all NUM_REQ requesters valid continuously, each is granted exactly once every NUM_REQ cycles.
- Same-address requests in one cycle: only the granted requester writes. The other writes in a later cycle, so the later grant is the final value. No merging.
- HOLD asserted:
  - No new grants. The next edge drives REG_WRITE_ENABLE=0.
  - A write already registered still completes, because it is already on the outputs.
  - LAST is unchanged.
- Reset mid-operation: an in-flight registered write is dropped (REG_WRITE_ENABLE forced to 0 asynchronously). LAST returns to NUM_REQ-1.
- A requester deasserting VALID without a grant is tolerated. Its PENDING bit clears on the next edge.

Optional Feature:
- Macro: REG_WR_ARB_XZR_DROP_EN.
- Defined: a granted request with REQ_ADDR=31 (zero register) still handshakes normally and updates LAST and GRANT_ID. REG_WRITE_ENABLE<=0 for that cycle and WRITE_REG/WRITE_DATA hold, so register 31 is never written.
- Undefined: address 31 is treated like any other address and written normally.

Test Plan:
- Reset check: assert RST_N=0 mid-cycle with VALID=3'b111 -> REG_WRITE_ENABLE, PENDING and REQ_READY=0 immediately. After release, the first grant goes to requester 0.
- Single requester: REQ_VALID=3'b010, ADDR1=7, DATA1=64'h1234 -> READY=3'b010 in the same cycle. The next edge gives REG_WRITE_ENABLE=1, WRITE_REG=7, WRITE_DATA=64'h1234, GRANT_ID=1.
- Round-robin: VALID=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2. PENDING is nonzero for the waiting requesters.
- Collision: requesters 0 and 2 both target reg 4 with data 'hAA and 'hBB -> two consecutive writes to reg 4, 'hAA then 'hBB, and the register file ends at 'hBB.
- HOLD: VALID=3'b001 with HOLD=1 for 3 cycles -> READY=0 and REG_WRITE_ENABLE=0 throughout, PENDING[0]=1. Dropping HOLD grants the request in the next cycle.
- XZR (macro defined): ADDR0=31, DATA0=64'hFFFF -> READY=1, GRANT_ID=0, REG_WRITE_ENABLE stays 0. With the macro undefined, the same stimulus writes reg 31 with 64'hFFFF.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Purpose:
//   Shares the single synchronous write port of the 32x64 register file
//   among NUM_REQ writeback sources (ALU, load, debug/init, ...). One source
//   is granted per cycle with round-robin priority and a valid/ready
//   handshake. The register-file write strobe, address and data are driven
//   from flops, so the register file captures a write one edge after the
//   handshake edge.
//
// Ports:
//   CLK              system clock, rising edge
//   RST_N            asynchronous active-low reset
//   HOLD             stall; no grant is issued while high
//   REQ_VALID        per-requester write request
//   REQ_ADDR         packed destination registers, requester i at [i*ADDR_W +: ADDR_W]
//   REQ_DATA         packed write data, requester i at [i*DATA_W +: DATA_W]
//   REQ_READY        one-hot grant (combinational)
//   REG_WRITE_ENABLE registered write strobe to the register file
//   WRITE_REG        registered write address
//   WRITE_DATA       registered write data
//   GRANT_ID         index of the requester that produced the current write
//   PENDING          registered; bit i set when requester i waited a cycle
//
// Configuration:
//   REG_WR_ARB_XZR_DROP_EN - when defined, a granted write to register 31
//   (zero register) still handshakes but does not strobe the register file.
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      HOLD,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]        REQ_READY,
    output logic                      REG_WRITE_ENABLE,
    output logic [ADDR_W-1:0]         WRITE_REG,
    output logic [DATA_W-1:0]         WRITE_DATA,
    output logic [2:0]                GRANT_ID,
    output logic [NUM_REQ-1:0]        PENDING
);

    localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

`ifdef REG_WR_ARB_XZR_DROP_EN
    localparam logic [ADDR_W-1:0] XZR_ADDR = ADDR_W'(31);
`endif

    logic [2:0]         last_q, last_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  wreg_q, wreg_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [2:0]         gid_q, gid_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;

    logic [7:0]         valid_ext;
    logic               grant_found;
    logic [2:0]         grant_idx;
    logic [2:0]         scan_idx;
    logic [NUM_REQ-1:0] req_ready;
    logic               handshake;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // Widened to 8 bits so the 3-bit scan index selects a bit without a
    // width mismatch for any NUM_REQ in 2..8.
    assign valid_ext = 8'(REQ_VALID);

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        scan_idx    = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = 3'((int'(last_q) + 1 + k) % NUM_REQ);
            if (!grant_found && valid_ext[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // READY is also held low during reset so no requester sees a grant that
    // the reset flops would never register.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_found && !HOLD && RST_N && (grant_idx == 3'(i));
        end
    end

    assign REQ_READY = req_ready;
    assign handshake = |req_ready;

    // Address/data mux; driven only by the grant index so REQ_ADDR and
    // REQ_DATA never feed REQ_READY.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
                sel_data = REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: a handshake loads the write port and moves the pointer;
    // otherwise the strobe drops and address/data/id hold.
    always_comb begin
        we_d      = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        gid_d     = gid_q;
        last_d    = last_q;
        pending_d = REQ_VALID & ~req_ready;
        if (handshake) begin
            last_d = grant_idx;
            gid_d  = grant_idx;
`ifdef REG_WR_ARB_XZR_DROP_EN
            if (sel_addr != XZR_ADDR) begin
                we_d    = 1'b1;
                wreg_d  = sel_addr;
                wdata_d = sel_data;
            end
`else
            we_d    = 1'b1;
            wreg_d  = sel_addr;
            wdata_d = sel_data;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q    <= LAST_RST;
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            gid_q     <= 3'd0;
            pending_q <= '0;
        end else begin
            last_q    <= last_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            gid_q     <= gid_d;
            pending_q <= pending_d;
        end
    end

    assign REG_WRITE_ENABLE = we_q;
    assign WRITE_REG        = wreg_q;
    assign WRITE_DATA       = wdata_q;
    assign GRANT_ID         = gid_q;
    assign PENDING          = pending_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Purpose:
//   Self-checking bench for reg_write_arbiter (NUM_REQ=3, ADDR_W=5,
//   DATA_W=64). Each scenario task drives requests, pushes the writes it
//   expects onto a scoreboard queue, and checks READY/PENDING/GRANT_ID
//   inline. A monitor pops the queue whenever the register-file strobe is
//   seen and keeps a small register-file model for final-value checks.
//   Follows REG_WR_ARB_XZR_DROP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

    logic         CLK;
    logic         RST_N;
    logic         HOLD;
    logic [2:0]   REQ_VALID;
    logic [14:0]  REQ_ADDR;
    logic [191:0] REQ_DATA;
    logic [2:0]   REQ_READY;
    logic         REG_WRITE_ENABLE;
    logic [4:0]   WRITE_REG;
    logic [63:0]  WRITE_DATA;
    logic [2:0]   GRANT_ID;
    logic [2:0]   PENDING;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
        logic [2:0]  gid;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_entry;
    logic [63:0] rf_model [32];
    int          checks;
    int          errors;

    reg_write_arbiter #(
        .NUM_REQ(3),
        .ADDR_W (5),
        .DATA_W (64)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .HOLD            (HOLD),
        .REQ_VALID       (REQ_VALID),
        .REQ_ADDR        (REQ_ADDR),
        .REQ_DATA        (REQ_DATA),
        .REQ_READY       (REQ_READY),
        .REG_WRITE_ENABLE(REG_WRITE_ENABLE),
        .WRITE_REG       (WRITE_REG),
        .WRITE_DATA      (WRITE_DATA),
        .GRANT_ID        (GRANT_ID),
        .PENDING         (PENDING)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Scoreboard monitor: every strobe seen must match the oldest expected
    // write; the register-file model takes the write at the same time.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && REG_WRITE_ENABLE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got reg %0d data %h id %0d, required no write",
                         WRITE_REG, WRITE_DATA, GRANT_ID);
            end else begin
                mon_entry = exp_q.pop_front();
                if (WRITE_REG !== mon_entry.addr || WRITE_DATA !== mon_entry.data ||
                    GRANT_ID !== mon_entry.gid) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_write: got reg %0d data %h id %0d, required reg %0d data %h id %0d",
                             WRITE_REG, WRITE_DATA, GRANT_ID,
                             mon_entry.addr, mon_entry.data, mon_entry.gid);
                end
            end
            rf_model[WRITE_REG] = WRITE_DATA;
        end
    end

    // Stimulus helper: load one requester's address/data slice.
    task automatic set_req(input int idx, input logic [4:0] a, input logic [63:0] d);
        REQ_ADDR[idx*5 +: 5]   = a;
        REQ_DATA[idx*64 +: 64] = d;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        set_req(0, 5'd1, 64'hD0);
        set_req(1, 5'd2, 64'hD1);
        set_req(2, 5'd3, 64'hD2);
        REQ_VALID = 3'b111;
        #1;
        checks++;
        if (REQ_READY !== 3'b000 || REG_WRITE_ENABLE !== 1'b0 || PENDING !== 3'b000 ||
            GRANT_ID !== 3'd0 || WRITE_REG !== 5'd0 || WRITE_DATA !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got ready %b we %b pend %b id %0d reg %0d data %h, required all zero",
                     REQ_READY, REG_WRITE_ENABLE, PENDING, GRANT_ID, WRITE_REG, WRITE_DATA);
        end
        RST_N = 1'b1;
        #1;
        checks++;
        if (REQ_READY !== 3'b001) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got ready %b, required 001", REQ_READY);
        end
        exp_q.push_back('{5'd1, 64'hD0, 3'd0});
        @(posedge CLK); #1;
        checks++;
        if (REG_WRITE_ENABLE !== 1'b1 || GRANT_ID !== 3'd0 || PENDING !== 3'b110) begin
            errors++;
            $display("[TB] FAIL reset_first_write: got we %b id %0d pend %b, required we 1 id 0 pend 110",
                     REG_WRITE_ENABLE, GRANT_ID, PENDING);
        end
        // Reset mid-cycle while a write sits on the outputs.
        @(negedge CLK); #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (REG_WRITE_ENABLE !== 1'b0 || PENDING !== 3'b000 || REQ_READY !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_async: got we %b pend %b ready %b, required 0 000 000",
                     REG_WRITE_ENABLE, PENDING, REQ_READY);
        end
        RST_N = 1'b1;
        #1;
        checks++;
        if (REQ_READY !== 3'b001) begin
            errors++;
            $display("[TB] FAIL reset_pointer: got ready %b, required 001", REQ_READY);
        end
        exp_q.push_back('{5'd1, 64'hD0, 3'd0});
        @(posedge CLK); #1;
        REQ_VALID = 3'b000;
        checks++;
        if (GRANT_ID !== 3'd0 || REG_WRITE_ENABLE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_regrant: got id %0d we %b, required id 0 we 1",
                     GRANT_ID, REG_WRITE_ENABLE);
        end
    endtask

    task automatic test_single();
        @(negedge CLK);
        set_req(1, 5'd7, 64'h1234);
        REQ_VALID = 3'b010;
        #1;
        checks++;
        if (REQ_READY !== 3'b010) begin
            errors++;
            $display("[TB] FAIL single_ready: got %b, required 010", REQ_READY);
        end
        exp_q.push_back('{5'd7, 64'h1234, 3'd1});
        @(posedge CLK); #1;
        REQ_VALID = 3'b000;
        checks++;
        if (REG_WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd7 || WRITE_DATA !== 64'h1234 ||
            GRANT_ID !== 3'd1) begin
            errors++;
            $display("[TB] FAIL single_write: got we %b reg %0d data %h id %0d, required 1 7 1234 1",
                     REG_WRITE_ENABLE, WRITE_REG, WRITE_DATA, GRANT_ID);
        end
        @(posedge CLK); #1;
        checks++;
        if (REG_WRITE_ENABLE !== 1'b0 || WRITE_REG !== 5'd7 || GRANT_ID !== 3'd1) begin
            errors++;
            $display("[TB] FAIL single_hold_outputs: got we %b reg %0d id %0d, required 0 7 1",
                     REG_WRITE_ENABLE, WRITE_REG, GRANT_ID);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_onehot;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 64'(64'h100 + i));
        REQ_VALID = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_onehot = 3'b001 << (k % 3);
            #1;
            checks++;
            if (REQ_READY !== exp_onehot) begin
                errors++;
                $display("[TB] FAIL rr_ready_%0d: got %b, required %b", k, REQ_READY, exp_onehot);
            end
            exp_q.push_back('{5'(10 + k % 3), 64'(64'h100 + k % 3), 3'(k % 3)});
            @(posedge CLK); #1;
            checks++;
            if (GRANT_ID !== 3'(k % 3) || PENDING !== (3'b111 & ~exp_onehot) ||
                REG_WRITE_ENABLE !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_grant_%0d: got id %0d pend %b we %b, required id %0d pend %b we 1",
                         k, GRANT_ID, PENDING, REG_WRITE_ENABLE, k % 3, 3'b111 & ~exp_onehot);
            end
        end
        REQ_VALID = 3'b000;
    endtask

    task automatic test_collision();
        @(negedge CLK);
        set_req(0, 5'd4, 64'hAA);
        set_req(2, 5'd4, 64'hBB);
        REQ_VALID = 3'b101;
        #1;
        checks++;
        if (REQ_READY !== 3'b001) begin
            errors++;
            $display("[TB] FAIL coll_ready0: got %b, required 001", REQ_READY);
        end
        exp_q.push_back('{5'd4, 64'hAA, 3'd0});
        exp_q.push_back('{5'd4, 64'hBB, 3'd2});
        @(posedge CLK); #1;
        REQ_VALID = 3'b100;
        checks++;
        if (WRITE_DATA !== 64'hAA || REG_WRITE_ENABLE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL coll_first: got data %h we %b, required aa 1", WRITE_DATA, REG_WRITE_ENABLE);
        end
        #1;
        checks++;
        if (REQ_READY !== 3'b100) begin
            errors++;
            $display("[TB] FAIL coll_ready2: got %b, required 100", REQ_READY);
        end
        @(posedge CLK); #1;
        REQ_VALID = 3'b000;
        checks++;
        if (WRITE_DATA !== 64'hBB || GRANT_ID !== 3'd2 || REG_WRITE_ENABLE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL coll_second: got data %h id %0d we %b, required bb 2 1",
                     WRITE_DATA, GRANT_ID, REG_WRITE_ENABLE);
        end
        @(negedge CLK); #1;
        checks++;
        if (rf_model[4] !== 64'hBB) begin
            errors++;
            $display("[TB] FAIL coll_final: got reg4 %h, required bb", rf_model[4]);
        end
    endtask

    task automatic test_xzr();
        @(negedge CLK);
        set_req(0, 5'd31, 64'hFFFF);
        REQ_VALID = 3'b001;
        #1;
        checks++;
        if (REQ_READY !== 3'b001) begin
            errors++;
            $display("[TB] FAIL xzr_ready: got %b, required 001", REQ_READY);
        end
`ifndef REG_WR_ARB_XZR_DROP_EN
        exp_q.push_back('{5'd31, 64'hFFFF, 3'd0});
`endif
        @(posedge CLK); #1;
        REQ_VALID = 3'b000;
`ifdef REG_WR_ARB_XZR_DROP_EN
        checks++;
        if (GRANT_ID !== 3'd0 || REG_WRITE_ENABLE !== 1'b0 || WRITE_REG !== 5'd4 ||
            WRITE_DATA !== 64'hBB) begin
            errors++;
            $display("[TB] FAIL xzr_drop: got id %0d we %b reg %0d data %h, required 0 0 4 bb",
                     GRANT_ID, REG_WRITE_ENABLE, WRITE_REG, WRITE_DATA);
        end
`else
        checks++;
        if (GRANT_ID !== 3'd0 || REG_WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd31 ||
            WRITE_DATA !== 64'hFFFF) begin
            errors++;
            $display("[TB] FAIL xzr_write: got id %0d we %b reg %0d data %h, required 0 1 31 ffff",
                     GRANT_ID, REG_WRITE_ENABLE, WRITE_REG, WRITE_DATA);
        end
`endif
        // Pointer must have moved to 0 even when the write was dropped.
        set_req(1, 5'd9, 64'h99);
        REQ_VALID = 3'b011;
        #1;
        checks++;
        if (REQ_READY !== 3'b010) begin
            errors++;
            $display("[TB] FAIL xzr_pointer: got ready %b, required 010", REQ_READY);
        end
        exp_q.push_back('{5'd9, 64'h99, 3'd1});
        @(posedge CLK); #1;
        REQ_VALID = 3'b000;
        @(negedge CLK); #1;
        checks++;
`ifdef REG_WR_ARB_XZR_DROP_EN
        if (rf_model[31] !== 64'd0) begin
            errors++;
            $display("[TB] FAIL xzr_reg31: got %h, required 0", rf_model[31]);
        end
`else
        if (rf_model[31] !== 64'hFFFF) begin
            errors++;
            $display("[TB] FAIL xzr_reg31: got %h, required ffff", rf_model[31]);
        end
`endif
    endtask

    task automatic test_hold();
        @(negedge CLK);
        HOLD = 1'b1;
        set_req(0, 5'd5, 64'h55);
        REQ_VALID = 3'b001;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (REQ_READY !== 3'b000) begin
                errors++;
                $display("[TB] FAIL hold_ready_%0d: got %b, required 000", c, REQ_READY);
            end
            @(posedge CLK); #1;
            checks++;
            if (REG_WRITE_ENABLE !== 1'b0 || PENDING !== 3'b001) begin
                errors++;
                $display("[TB] FAIL hold_state_%0d: got we %b pend %b, required 0 001",
                         c, REG_WRITE_ENABLE, PENDING);
            end
        end
        HOLD = 1'b0;
        #1;
        checks++;
        if (REQ_READY !== 3'b001) begin
            errors++;
            $display("[TB] FAIL hold_release_ready: got %b, required 001", REQ_READY);
        end
        exp_q.push_back('{5'd5, 64'h55, 3'd0});
        @(posedge CLK); #1;
        REQ_VALID = 3'b000;
        checks++;
        if (REG_WRITE_ENABLE !== 1'b1 || GRANT_ID !== 3'd0 || PENDING !== 3'b000) begin
            errors++;
            $display("[TB] FAIL hold_release_write: got we %b id %0d pend %b, required 1 0 000",
                     REG_WRITE_ENABLE, GRANT_ID, PENDING);
        end
    endtask

    // Scenario sequence; the pointer state left by each task feeds the next.
    initial begin
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        HOLD      = 1'b0;
        REQ_VALID = 3'b000;
        REQ_ADDR  = '0;
        REQ_DATA  = '0;
        for (int r = 0; r < 32; r++) rf_model[r] = 64'd0;

        test_reset();
        test_single();
        test_round_robin();
        test_collision();
        test_xzr();
        test_hold();

        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
